// File: rtl/ifmap_fifo.sv
// ifmap_fifo: FWFT ifmap buffer behind the decompressor, with layer drain/done tracking.
// Define IFMAP_FIFO_STATS_EN to add the max_count / stall_cycles statistics ports.
module ifmap_fifo #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 16,
    parameter int AFULL_SLACK = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    layer_done,
    input  logic                    packet_valid,
    input  logic [DATA_W-1:0]       packet_data,
    output logic                    ifmap_buffer_req,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  count,
`ifdef IFMAP_FIFO_STATS_EN
    output logic [$clog2(DEPTH):0]  max_count,
    output logic [31:0]             stall_cycles,
`endif
    output logic                    fifo_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_SLACK);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;
    logic              pop;

    assign ifmap_buffer_req = (state == RUN) && (count < AFULL_LVL);
    assign rd_valid         = (count != '0);
    assign fifo_done        = (state == DONE);
    assign rd_data          = rd_valid ? mem[rd_ptr] : '0;

    // start flushes the buffer, so it suppresses any same-cycle push or pop
    assign push = packet_valid && ifmap_buffer_req && !start;
    assign pop  = rd_en && rd_valid && !start;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = IDLE;
            RUN:   if (layer_done) state_nxt = (count == '0) ? DONE : DRAIN;
            DRAIN: if (count == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= packet_data;
        end
    end

`ifdef IFMAP_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_count    <= '0;
            stall_cycles <= '0;
        end else if (start) begin
            max_count    <= '0;
            stall_cycles <= '0;
        end else begin
            if (count_nxt > max_count) begin
                max_count <= count_nxt;
            end
            if ((state == RUN) && packet_valid && !ifmap_buffer_req &&
                (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule
